// File: rtl/memory_pkg.sv
// Shared helpers for the dual-port arilla-bus memory.
//   local_addr_width : word-address bits needed to index the RAM
//   device_field     : value the upper address bits must match for a hit
//   read_latency_ok  : legality of the ReadLatency parameter
package memory_pkg;

  function automatic int unsigned local_addr_width(input int unsigned size_bytes,
                                                   input int unsigned bytes_per_word);
    return $clog2(size_bytes / bytes_per_word);
  endfunction

  // The device field is the same whether taken from the byte address
  // (shift by log2(size)) or the word address (shift by log2(words)).
  function automatic logic [31:0] device_field(input logic [31:0] base_address,
                                               input int unsigned size_bytes);
    return base_address >> $clog2(size_bytes);
  endfunction

  function automatic bit read_latency_ok(input int unsigned read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// arilla bus: word-addressed request from a master, read data returned
// on a tri-stated data_ptc after the slave's read latency.
//   address     : word address
//   read/write  : request strobes
//   byte_enable : write lane select, one bit per byte
//   data_ctp    : write data (core to peripheral)
//   data_ptc    : read data (peripheral to core), 'z when not driven
//   intercept   : another agent owns data_ptc this cycle
interface arilla_bus_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 30
) ();

  logic [AddressWidth-1:0]  address;
  logic                     read;
  logic                     write;
  logic [DataWidth/8-1:0]   byte_enable;
  logic [DataWidth-1:0]     data_ctp;
  logic [DataWidth-1:0]     data_ptc;
  logic                     intercept;

  modport slave (
    input  address,
    input  read,
    input  write,
    input  byte_enable,
    input  data_ctp,
    input  intercept,
    output data_ptc
  );

  modport master (
    output address,
    output read,
    output write,
    output byte_enable,
    output data_ctp,
    output intercept,
    input  data_ptc
  );

endinterface

// File: rtl/memory_port_ctrl.sv
// Per-port control for memory_dual_port.
//   clk, rst_n   : clock, synchronous active-low reset
//   address      : word address from the bus
//   read, write  : bus strobes
//   intercept    : suppresses data_ptc in the cycle it is high
//   rd_word      : RAM read register for this port
//   data_ptc     : tri-stated read data towards the bus
//   local_addr   : RAM word index
//   wr_en, rd_en : qualified (hit, out of reset) write/read strobes
module memory_port_ctrl #(
  parameter int unsigned           DataWidth    = 32,
  parameter int unsigned           AddressWidth = 30,
  parameter int unsigned           LocalAw      = 14,
  parameter logic [AddressWidth-1:0] DeviceField = '0,
  parameter int unsigned           ReadLatency  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddressWidth-1:0] address,
  input  logic                    read,
  input  logic                    write,
  input  logic                    intercept,
  input  logic [DataWidth-1:0]    rd_word,
  output logic [DataWidth-1:0]    data_ptc,
  output logic [LocalAw-1:0]      local_addr,
  output logic                    wr_en,
  output logic                    rd_en
);

  logic                   hit;
  logic                   drive;
  logic [ReadLatency-1:0] rd_valid;
  logic [DataWidth-1:0]   out_word;

  assign hit        = (address >> LocalAw) == DeviceField;
  assign local_addr = address[LocalAw-1:0];
  assign wr_en      = hit && write && rst_n;
  assign rd_en      = hit && read && rst_n;

  if (ReadLatency == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rst_n) rd_valid <= '0;
      else        rd_valid <= rd_en;
    end
    assign out_word = rd_word;
  end else begin : g_lat2
    logic [DataWidth-1:0] out_q;

    always_ff @(posedge clk) begin
      if (!rst_n) rd_valid <= '0;
      else        rd_valid <= {rd_valid[0], rd_en};
    end

    // Output register: holds the word captured as a request moves to the
    // final stage, so the RAM read register is free for the next request.
    always_ff @(posedge clk) begin
      if (rd_valid[0]) out_q <= rd_word;
    end
    assign out_word = out_q;
  end

  // Gated by rst_n so a request already in flight when reset asserts
  // never reaches the bus.
  assign drive    = rd_valid[ReadLatency-1] && !intercept && rst_n;
  assign data_ptc = drive ? out_word : 'z;

endmodule

// File: rtl/memory_dual_port.sv
// Dual-port RAM slave on two arilla buses.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus0, bus1      : independent slave ports; port 0 wins write collisions
//   collision_count : saturating count of port 1 writes suppressed by a
//                     same-word port 0 write in the same cycle
module memory_dual_port
  import memory_pkg::*;
#(
  parameter logic [31:0] BaseAddress         = 32'h0,
  parameter int unsigned SizeBytes           = 65536,
  parameter int unsigned ReadLatency         = 1,
  parameter              InitFile            = "UNUSED",
  parameter int unsigned CollisionCountWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  arilla_bus_if.slave                    bus0,
  arilla_bus_if.slave                    bus1,
  output logic [CollisionCountWidth-1:0] collision_count
);

  localparam int unsigned DataWidth    = $bits(bus0.data_ctp);
  localparam int unsigned AddressWidth = $bits(bus0.address);
  localparam int unsigned BytesPerWord = DataWidth / 8;
  localparam int unsigned Words        = SizeBytes / BytesPerWord;
  localparam int unsigned LocalAw      = local_addr_width(SizeBytes, BytesPerWord);
  localparam logic [31:0] DevField32   = device_field(BaseAddress, SizeBytes);
  localparam logic [AddressWidth-1:0] DevField = DevField32[AddressWidth-1:0];

  if (!read_latency_ok(ReadLatency)) begin : g_bad_read_latency
    $error("memory_dual_port: ReadLatency must be 1 or 2");
  end
  if ((BaseAddress % SizeBytes) != 0) begin : g_bad_base
    $error("memory_dual_port: BaseAddress must be aligned to SizeBytes");
  end
  if (InitFile != "UNUSED") begin : g_init_note
    $warning("memory_dual_port: InitFile preload is applied by the memory-initialisation flow");
  end

  logic [LocalAw-1:0]   addr0;
  logic [LocalAw-1:0]   addr1;
  logic                 wr_en0;
  logic                 wr_en1;
  logic                 rd_en0;
  logic                 rd_en1;
  logic                 wr_en1_eff;
  logic                 collision;
  logic [DataWidth-1:0] q0;
  logic [DataWidth-1:0] q1;
  logic [DataWidth-1:0] ptc0;
  logic [DataWidth-1:0] ptc1;
  logic [DataWidth-1:0] mem [Words];

  memory_port_ctrl #(
    .DataWidth    (DataWidth),
    .AddressWidth (AddressWidth),
    .LocalAw      (LocalAw),
    .DeviceField  (DevField),
    .ReadLatency  (ReadLatency)
  ) u_port0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (bus0.address),
    .read       (bus0.read),
    .write      (bus0.write),
    .intercept  (bus0.intercept),
    .rd_word    (q0),
    .data_ptc   (ptc0),
    .local_addr (addr0),
    .wr_en      (wr_en0),
    .rd_en      (rd_en0)
  );

  memory_port_ctrl #(
    .DataWidth    (DataWidth),
    .AddressWidth (AddressWidth),
    .LocalAw      (LocalAw),
    .DeviceField  (DevField),
    .ReadLatency  (ReadLatency)
  ) u_port1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (bus1.address),
    .read       (bus1.read),
    .write      (bus1.write),
    .intercept  (bus1.intercept),
    .rd_word    (q1),
    .data_ptc   (ptc1),
    .local_addr (addr1),
    .wr_en      (wr_en1),
    .rd_en      (rd_en1)
  );

  assign bus0.data_ptc = ptc0;
  assign bus1.data_ptc = ptc1;

  // Whole-word suppression: port 1 loses every lane, not just overlapping ones.
  assign collision  = wr_en0 && wr_en1 && (addr0 == addr1);
  assign wr_en1_eff = wr_en1 && !collision;

  // Both ports in one block so the array has a single writer; non-blocking
  // reads give old data for same-port and cross-port read-during-write.
  always_ff @(posedge clk) begin
    if (rd_en0) q0 <= mem[addr0];
    if (rd_en1) q1 <= mem[addr1];
    for (int unsigned b = 0; b < BytesPerWord; b++) begin
      if (wr_en0 && bus0.byte_enable[b]) mem[addr0][b*8 +: 8] <= bus0.data_ctp[b*8 +: 8];
      if (wr_en1_eff && bus1.byte_enable[b]) mem[addr1][b*8 +: 8] <= bus1.data_ctp[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision_count <= '0;
    end else if (collision && (collision_count != '1)) begin
      collision_count <= collision_count + CollisionCountWidth'(1);
    end
  end

endmodule

// File: tb/tb_memory_dual_port.sv
module tb_memory_dual_port;

  logic        clk;
  logic        rst_n;
  logic [15:0] count_l1;
  logic [15:0] count_l2;
  int          checks = 0;
  int          errors = 0;

  arilla_bus_if #(.DataWidth(32), .AddressWidth(30)) a0 ();
  arilla_bus_if #(.DataWidth(32), .AddressWidth(30)) a1 ();
  arilla_bus_if #(.DataWidth(32), .AddressWidth(30)) b0 ();
  arilla_bus_if #(.DataWidth(32), .AddressWidth(30)) b1 ();

  memory_dual_port #(
    .BaseAddress         (32'h0),
    .SizeBytes           (65536),
    .ReadLatency         (1),
    .InitFile            ("UNUSED"),
    .CollisionCountWidth (16)
  ) dut_l1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus0            (a0),
    .bus1            (a1),
    .collision_count (count_l1)
  );

  memory_dual_port #(
    .BaseAddress         (32'h0001_0000),
    .SizeBytes           (65536),
    .ReadLatency         (2),
    .InitFile            ("UNUSED"),
    .CollisionCountWidth (16)
  ) dut_l2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus0            (b0),
    .bus1            (b1),
    .collision_count (count_l2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a0.read = 0; a0.write = 0; a0.address = '0; a0.data_ctp = '0; a0.byte_enable = '0; a0.intercept = 0;
    a1.read = 0; a1.write = 0; a1.address = '0; a1.data_ctp = '0; a1.byte_enable = '0; a1.intercept = 0;
    b0.read = 0; b0.write = 0; b0.address = '0; b0.data_ctp = '0; b0.byte_enable = '0; b0.intercept = 0;
    b1.read = 0; b1.write = 0; b1.address = '0; b1.data_ctp = '0; b1.byte_enable = '0; b1.intercept = 0;
  endtask

  // p: 0/1 = ports of the latency-1 instance, 2/3 = ports of the latency-2 instance
  task automatic drv(input int unsigned p, input logic rd, input logic wr,
                     input logic [29:0] addr, input logic [31:0] data, input logic [3:0] be);
    case (p)
      0: begin a0.read = rd; a0.write = wr; a0.address = addr; a0.data_ctp = data; a0.byte_enable = be; end
      1: begin a1.read = rd; a1.write = wr; a1.address = addr; a1.data_ctp = data; a1.byte_enable = be; end
      2: begin b0.read = rd; b0.write = wr; b0.address = addr; b0.data_ctp = data; b0.byte_enable = be; end
      default: begin b1.read = rd; b1.write = wr; b1.address = addr; b1.data_ctp = data; b1.byte_enable = be; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // An undriven bus reads 'z on a four-state simulator and 0 on a two-state one.
  task automatic chk_z(input string tag, input logic [31:0] obs);
    checks++;
    assert ((obs === 32'hzzzz_zzzz) || (obs === 32'h0)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=zzzzzzzz", tag, obs);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    tick();
    tick();
    chk("rst_count_l1", {16'h0, count_l1}, 32'h0);
    chk("rst_count_l2", {16'h0, count_l2}, 32'h0);
    chk_z("rst_p0_idle", a0.data_ptc);
    chk_z("rst_p1_idle", a1.data_ptc);
    rst_n = 1'b1;
    tick();

    // Full-word write then latency-1 read.
    idle_all(); drv(0, 0, 1, 30'h10, 32'hDEADBEEF, 4'hF); tick();
    idle_all(); chk_z("l1_before", a0.data_ptc);
    drv(0, 1, 0, 30'h10, '0, '0); tick();
    idle_all();
    chk("l1_read", a0.data_ptc, 32'hDEADBEEF);
    chk_z("l1_p1_quiet", a1.data_ptc);
    tick();
    chk_z("l1_after", a0.data_ptc);

    // Partial write from port 1 over zero.
    idle_all(); drv(0, 0, 1, 30'h20, 32'h0, 4'hF); tick();
    idle_all(); drv(1, 0, 1, 30'h20, 32'hAABBCCDD, 4'b0101); tick();
    idle_all(); drv(0, 1, 0, 30'h20, '0, '0); tick();
    idle_all(); chk("partial_be", a0.data_ptc, 32'h00BB00DD);

    // Write collision: port 0 wins, counter counts.
    idle_all();
    drv(0, 0, 1, 30'h30, 32'h11111111, 4'hF);
    drv(1, 0, 1, 30'h30, 32'h22222222, 4'hF);
    tick();
    idle_all(); chk("coll_count1", {16'h0, count_l1}, 32'h1);
    drv(0, 1, 0, 30'h30, '0, '0); drv(1, 1, 0, 30'h30, '0, '0); tick();
    idle_all();
    chk("coll_read_p0", a0.data_ptc, 32'h11111111);
    chk("coll_read_p1", a1.data_ptc, 32'h11111111);

    // Saturation: 65539 collisions in total.
    drv(0, 0, 1, 30'h30, 32'h11111111, 4'hF);
    drv(1, 0, 1, 30'h30, 32'h22222222, 4'hF);
    repeat (65533) tick();
    chk("coll_count_fffe", {16'h0, count_l1}, 32'hFFFE);
    tick();
    chk("coll_count_ffff", {16'h0, count_l1}, 32'hFFFF);
    repeat (4) tick();
    chk("coll_count_sat", {16'h0, count_l1}, 32'hFFFF);

    // Port 1 loses non-overlapping lanes too.
    idle_all(); drv(0, 0, 1, 30'h31, 32'h0, 4'hF); tick();
    idle_all();
    drv(0, 0, 1, 30'h31, 32'h000000AA, 4'b0001);
    drv(1, 0, 1, 30'h31, 32'h12345600, 4'b1110);
    tick();
    idle_all(); drv(0, 1, 0, 30'h31, '0, '0); tick();
    idle_all(); chk("lane_suppress", a0.data_ptc, 32'h000000AA);

    // Simultaneous writes to different words, then crossed reads.
    drv(0, 0, 1, 30'h50, 32'hA5A5A5A5, 4'hF);
    drv(1, 0, 1, 30'h51, 32'h5A5A5A5A, 4'hF);
    tick();
    idle_all(); drv(0, 1, 0, 30'h51, '0, '0); drv(1, 1, 0, 30'h50, '0, '0); tick();
    idle_all();
    chk("diff_word_p0", a0.data_ptc, 32'h5A5A5A5A);
    chk("diff_word_p1", a1.data_ptc, 32'hA5A5A5A5);

    // Cross-port read-during-write returns old data.
    drv(0, 0, 1, 30'h40, 32'h5, 4'hF); tick();
    idle_all(); drv(0, 0, 1, 30'h40, 32'h9, 4'hF); drv(1, 1, 0, 30'h40, '0, '0); tick();
    idle_all(); chk("xport_rdw_old", a1.data_ptc, 32'h5);
    drv(1, 1, 0, 30'h40, '0, '0); tick();
    idle_all(); chk("xport_rdw_new", a1.data_ptc, 32'h9);

    // Same-port read-during-write returns old data.
    drv(0, 0, 1, 30'h41, 32'h7, 4'hF); tick();
    idle_all(); drv(0, 1, 1, 30'h41, 32'h8, 4'hF); tick();
    idle_all(); chk("same_rdw_old", a0.data_ptc, 32'h7);
    drv(0, 1, 0, 30'h41, '0, '0); tick();
    idle_all(); chk("same_rdw_new", a0.data_ptc, 32'h8);

    // Intercept in the data cycle blocks the drive.
    drv(0, 1, 0, 30'h10, '0, '0); tick();
    idle_all(); a0.intercept = 1; #1;
    chk_z("l1_intercept", a0.data_ptc);
    a0.intercept = 0;

    // Reset one cycle after a read; writes during reset ignored.
    idle_all(); tick();
    drv(0, 1, 0, 30'h40, '0, '0); tick();
    idle_all(); rst_n = 1'b0; drv(1, 0, 1, 30'h40, 32'h0BADBEEF, 4'hF); #1;
    chk_z("rst_midread", a0.data_ptc);
    tick();
    chk_z("rst_midread2", a0.data_ptc);
    chk("rst_count_clr", {16'h0, count_l1}, 32'h0);
    idle_all(); rst_n = 1'b1; tick();
    drv(0, 1, 0, 30'h40, '0, '0); tick();
    idle_all(); chk("ram_survives", a0.data_ptc, 32'h9);

    // Out-of-window port 1 write aliasing port 0's local word.
    drv(0, 0, 1, 30'h10, 32'hCAFEF00D, 4'hF);
    drv(1, 0, 1, 30'h4010, 32'hBAD0BAD0, 4'hF);
    tick();
    idle_all(); chk("oow_no_count", {16'h0, count_l1}, 32'h0);
    drv(0, 1, 0, 30'h10, '0, '0); drv(1, 1, 0, 30'h4010, '0, '0); tick();
    idle_all();
    chk("oow_no_write", a0.data_ptc, 32'hCAFEF00D);
    chk_z("oow_no_drive", a1.data_ptc);

    // Latency 2 at base 0x10000 (word 0x4000): back-to-back reads.
    drv(2, 0, 1, 30'h4000, 32'h100, 4'hF); tick();
    drv(2, 0, 1, 30'h4001, 32'h101, 4'hF); tick();
    drv(2, 0, 1, 30'h4002, 32'h102, 4'hF); tick();
    idle_all();
    drv(2, 1, 0, 30'h4000, '0, '0); tick();
    chk_z("l2_plus1", b0.data_ptc);
    drv(2, 1, 0, 30'h4001, '0, '0); tick();
    chk("l2_word0", b0.data_ptc, 32'h100);
    drv(2, 1, 0, 30'h4002, '0, '0); b0.intercept = 1; tick();
    chk_z("l2_intercepted", b0.data_ptc);
    idle_all(); tick();
    chk("l2_word2", b0.data_ptc, 32'h102);
    tick();
    chk_z("l2_after", b0.data_ptc);

    // Latency 2: address below the window.
    drv(2, 1, 0, 30'h10, '0, '0); tick();
    idle_all(); tick();
    chk_z("l2_oow", b0.data_ptc);
    chk("l2_count", {16'h0, count_l2}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
